// File: rtl/freq_count_sequencer_if.sv
// Bundled stream/counter/output signals between freq_count_sequencer and its neighbours.
// master = sequencer side; slave = environment (source, frequency_counter, sink).
interface freq_count_sequencer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;

  logic        cnt_clr;
  logic [7:0]  cnt_symbol;
  logic        cnt_load;
  logic        cnt_done;
  logic [7:0]  cnt_addr;
  logic [23:0] cnt_freq;

  logic [7:0]  out_symbol;
  logic [23:0] out_freq;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  modport master (
    input  in_data, in_valid, in_last, cnt_done, cnt_freq, out_ready,
    output in_ready, cnt_clr, cnt_symbol, cnt_load, cnt_addr,
           out_symbol, out_freq, out_valid, out_last
  );

  modport slave (
    output in_data, in_valid, in_last, cnt_done, cnt_freq, out_ready,
    input  in_ready, cnt_clr, cnt_symbol, cnt_load, cnt_addr,
           out_symbol, out_freq, out_valid, out_last
  );
endinterface

// File: rtl/freq_count_sequencer.sv
// Sequences a frequency_counter over one frame, then emits non-zero (symbol, freq) pairs in order.
// Optional handshake watchdog enabled by defining FCS_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start
// S_CLEAR   | counter reset pulse, frame statistics zeroed
// S_ACCEPT  | in_ready high, waiting for an input beat
// S_LOAD    | cnt_load held high until the counter acknowledges
// S_RELEASE | waiting for the counter to drop done before the next load
// S_SCAN    | one table entry examined per cycle
// S_EMIT    | pair held on out_* until out_ready
// S_DONE    | one-cycle completion pulse
// S_ERR     | watchdog expired; idle until the next start
module freq_count_sequencer #(
  parameter int unsigned TOTAL_W        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  freq_count_sequencer_if.master    bus,
  input  logic                      start_i,
  output logic [TOTAL_W-1:0]        total_count_o,
  output logic [8:0]                distinct_count_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_ACCEPT, S_LOAD, S_RELEASE, S_SCAN, S_EMIT, S_DONE, S_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_symbol_q, cnt_symbol_d;
  logic                 cnt_load_q, cnt_load_d;
  logic [7:0]           cnt_addr_q, cnt_addr_d;
  logic [7:0]           out_symbol_q, out_symbol_d;
  logic [23:0]          out_freq_q, out_freq_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [8:0]           distinct_q, distinct_d;
  logic [7:0]           max_sym_q, max_sym_d;
  logic                 last_seen_q, last_seen_d;

`ifdef FCS_TIMEOUT_EN
  localparam int unsigned    TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_symbol_d = cnt_symbol_q;
    cnt_load_d   = cnt_load_q;
    cnt_addr_d   = cnt_addr_q;
    out_symbol_d = out_symbol_q;
    out_freq_d   = out_freq_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    total_d      = total_q;
    distinct_d   = distinct_q;
    max_sym_d    = max_sym_q;
    last_seen_d  = last_seen_q;
`ifdef FCS_TIMEOUT_EN
    tmr_d        = tmr_q;
    err_d        = err_q;
`endif

    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_CLEAR;
      S_CLEAR: begin
        total_d     = '0;
        distinct_d  = '0;
        max_sym_d   = '0;
        last_seen_d = 1'b0;
`ifdef FCS_TIMEOUT_EN
        err_d       = 1'b0;
`endif
        state_d     = S_ACCEPT;
      end
      S_ACCEPT: if (bus.in_valid) begin
        cnt_symbol_d = bus.in_data;
        cnt_load_d   = 1'b1;
        if (bus.in_data > max_sym_q) max_sym_d = bus.in_data;
        last_seen_d  = bus.in_last;
        state_d      = S_LOAD;
      end
      S_LOAD: begin
        if (bus.cnt_done) begin
          cnt_load_d = 1'b0;
          if (total_q != '1) total_d = total_q + 1'b1;
          state_d    = S_RELEASE;
        end
`ifdef FCS_TIMEOUT_EN
        else if (tmr_q == '0) begin
          cnt_load_d = 1'b0;
          err_d      = 1'b1;
          state_d    = S_ERR;
        end
`endif
      end
      S_RELEASE: begin
        // Waiting for done to fall guarantees a fresh load edge at the counter.
        if (!bus.cnt_done) begin
          if (last_seen_q) begin
            cnt_addr_d = '0;
            state_d    = S_SCAN;
          end else begin
            state_d    = S_ACCEPT;
          end
        end
`ifdef FCS_TIMEOUT_EN
        else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
`endif
      end
      S_SCAN: begin
        if (bus.cnt_freq != '0) begin
          out_symbol_d = cnt_addr_q;
          out_freq_d   = bus.cnt_freq;
          out_valid_d  = 1'b1;
          out_last_d   = (cnt_addr_q == max_sym_q);
          distinct_d   = distinct_q + 9'd1;
          state_d      = S_EMIT;
        end else begin
          cnt_addr_d   = cnt_addr_q + 8'd1;
        end
      end
      S_EMIT: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        if (out_last_q) begin
          state_d    = S_DONE;
        end else begin
          cnt_addr_d = cnt_addr_q + 8'd1;
          state_d    = S_SCAN;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR:  if (start_i) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase

`ifdef FCS_TIMEOUT_EN
    // Down-counter reloads on every state change; only LOAD/RELEASE look at terminal count.
    if (state_d != state_q) tmr_d = TMR_LOAD;
    else if (tmr_q != '0)   tmr_d = tmr_q - 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_symbol_q <= '0;
      cnt_load_q   <= 1'b0;
      cnt_addr_q   <= '0;
      out_symbol_q <= '0;
      out_freq_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      total_q      <= '0;
      distinct_q   <= '0;
      max_sym_q    <= '0;
      last_seen_q  <= 1'b0;
`ifdef FCS_TIMEOUT_EN
      tmr_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_symbol_q <= cnt_symbol_d;
      cnt_load_q   <= cnt_load_d;
      cnt_addr_q   <= cnt_addr_d;
      out_symbol_q <= out_symbol_d;
      out_freq_q   <= out_freq_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      total_q      <= total_d;
      distinct_q   <= distinct_d;
      max_sym_q    <= max_sym_d;
      last_seen_q  <= last_seen_d;
`ifdef FCS_TIMEOUT_EN
      tmr_q        <= tmr_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.in_ready      = (state_q == S_ACCEPT);
  assign bus.cnt_clr       = (state_q == S_CLEAR);
  assign bus.cnt_symbol    = cnt_symbol_q;
  assign bus.cnt_load      = cnt_load_q;
  assign bus.cnt_addr      = cnt_addr_q;
  assign bus.out_symbol    = out_symbol_q;
  assign bus.out_freq      = out_freq_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_last      = out_last_q;
  assign total_count_o     = total_q;
  assign distinct_count_o  = distinct_q;
  assign busy_o            = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done_o            = (state_q == S_DONE);
`ifdef FCS_TIMEOUT_EN
  assign err_o             = err_q;
`else
  assign err_o             = 1'b0;
`endif

endmodule

// File: tb/tb_freq_count_sequencer.sv
// Directed scoreboard bench for freq_count_sequencer with a behavioural frequency_counter.
// Watchdog checks run only when FCS_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_freq_count_sequencer;
  localparam int unsigned TOTAL_W = 32;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [TOTAL_W-1:0] total_count;
  logic [8:0]         distinct_count;
  logic               busy, done, err;

  always #5 clk = ~clk;

  freq_count_sequencer_if bus();

  freq_count_sequencer #(.TOTAL_W(TOTAL_W), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .start_i          (start),
    .total_count_o    (total_count),
    .distinct_count_o (distinct_count),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err)
  );

  // behavioural frequency_counter: level load, done acknowledge, async read port
  logic [23:0] cmem [256];
  logic        cdone = 1'b0;
  logic        stall_done = 1'b0;
  initial for (int i = 0; i < 256; i++) cmem[i] = '0;
  always @(posedge clk) begin
    if (bus.cnt_clr === 1'b1) begin
      for (int i = 0; i < 256; i++) cmem[i] <= '0;
      cdone <= 1'b0;
    end else if (bus.cnt_load === 1'b1 && !cdone) begin
      cmem[bus.cnt_symbol] <= cmem[bus.cnt_symbol] + 24'd1;
      cdone <= 1'b1;
    end else if (bus.cnt_load === 1'b0) begin
      cdone <= 1'b0;
    end
  end
  assign bus.cnt_done = cdone & ~stall_done;
  assign bus.cnt_freq = cmem[bus.cnt_addr];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  sym;
    logic [23:0] freq;
    logic        last;
  } pair_t;
  pair_t exp_q[$];
  logic [7:0] stim_q[$];
  int last_pair_cyc = 0;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      check("pair_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        pair_t p;
        p = exp_q.pop_front();
        check("out_symbol", bus.out_symbol, p.sym);
        check("out_freq", bus.out_freq, p.freq);
        check("out_last", bus.out_last, p.last);
        if (bus.out_last === 1'b1) last_pair_cyc = cyc;
      end
    end
  end

  int addr_steps = 0;
  logic [7:0] prev_addr = '0;
  always @(negedge clk) begin
    if (bus.cnt_addr === prev_addr + 8'd1) addr_steps++;
    prev_addr = bus.cnt_addr;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input bit hold_first);
    int hist [256];
    int mx, ndist, k, last_hs, dcount;
    logic [7:0]  hs_sym;
    logic [23:0] hs_freq;
    mx = 0; ndist = 0;
    for (int s = 0; s < 256; s++) hist[s] = 0;
    foreach (stim_q[i]) begin
      hist[stim_q[i]]++;
      if (int'(stim_q[i]) > mx) mx = int'(stim_q[i]);
    end
    for (int s = 0; s < 256; s++)
      if (hist[s] != 0) begin
        exp_q.push_back('{8'(s), 24'(hist[s]), (s == mx)});
        ndist++;
      end
    addr_steps = 0;
    bus.out_ready = !hold_first;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("clr_pulse", bus.cnt_clr, 1'b1);
    tick();
    last_hs = 0;
    foreach (stim_q[i]) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stim_q[i];
      bus.in_last  = (i == stim_q.size() - 1);
      k = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      check("in_ready_wait", bus.in_ready, 1'b1);
      if (i == 0) check("start_to_ready", 64'(k), 64'd0);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (i > 0) check("handshake_spacing", 64'(cyc - last_hs), 64'd5);
      last_hs = cyc;
    end
    if (hold_first) begin
      k = 0;
      @(negedge clk);
      while (bus.out_valid !== 1'b1 && k < 600) begin @(negedge clk); k++; end
      check("hold_valid_seen", bus.out_valid, 1'b1);
      hs_sym  = bus.out_symbol;
      hs_freq = bus.out_freq;
      repeat (10) begin
        @(negedge clk);
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_symbol", bus.out_symbol, hs_sym);
        check("hold_freq", bus.out_freq, hs_freq);
      end
      tick();
      bus.out_ready = 1'b1;
    end
    k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 700) begin @(negedge clk); k++; end
    check("done_seen", done, 1'b1);
    check("done_latency", 64'(cyc - last_pair_cyc), 64'd1);
    dcount = 1;
    repeat (3) begin @(negedge clk); if (done === 1'b1) dcount++; end
    check("done_pulses", 64'(dcount), 64'd1);
    check("pairs_left", 64'(exp_q.size()), 64'd0);
    check("total_count", total_count, 64'(stim_q.size()));
    check("distinct_count", distinct_count, 64'(ndist));
    check("busy_after", busy, 1'b0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    repeat (3) begin
      start = 1'($urandom); bus.in_valid = 1'($urandom); bus.in_last = 1'($urandom);
      bus.in_data = 8'($urandom); bus.out_ready = 1'($urandom);
      tick();
    end
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_cnt_clr", bus.cnt_clr, 1'b0);
    check("rst_cnt_load", bus.cnt_load, 1'b0);
    check("rst_cnt_symbol", bus.cnt_symbol, 8'h00);
    check("rst_cnt_addr", bus.cnt_addr, 8'h00);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_pair", {bus.out_symbol, bus.out_freq, bus.out_last}, 33'h0);
    check("rst_total", total_count, 32'h0);
    check("rst_distinct", distinct_count, 9'h0);
    check("rst_status", {busy, done, err}, 3'b000);
    tick();
    start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    reset_n = 1'b1;
    tick();

    stim_q = '{8'h00, 8'h00, 8'h05, 8'h03};
    run_frame(1'b0);

    stim_q = '{8'hFF};
    run_frame(1'b0);
    check("sweep_steps", 64'(addr_steps), 64'd255);
    check("sweep_end_addr", bus.cnt_addr, 8'hFF);

    stim_q = '{8'h10, 8'h20, 8'h10};
    run_frame(1'b1);

    // mid-frame reset while stuck in LOAD, with a stray start while busy
    stall_done = 1'b1;
    start = 1'b1; tick(); start = 1'b0; tick();
    bus.in_valid = 1'b1; bus.in_data = 8'h07; bus.in_last = 1'b0;
    @(negedge clk);
    check("mid_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    check("busy_start_no_clr", bus.cnt_clr, 1'b0);
    check("mid_load_high", bus.cnt_load, 1'b1);
    check("mid_busy", busy, 1'b1);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    check("load_before_rst_edge", bus.cnt_load, 1'b1);
    @(negedge clk);
    check("load_at_rst_edge", bus.cnt_load, 1'b0);
    check("busy_at_rst_edge", busy, 1'b0);
    tick();
    reset_n = 1'b1;
    stall_done = 1'b0;
    tick();

    stim_q = '{8'h80, 8'h01, 8'h80, 8'h40};
    run_frame(1'b0);

`ifdef FCS_TIMEOUT_EN
    stall_done = 1'b1;
    start = 1'b1; tick(); start = 1'b0; tick();
    bus.in_valid = 1'b1; bus.in_data = 8'h42; bus.in_last = 1'b1;
    @(negedge clk);
    check("wd_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.cnt_load === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("wd_load_cycles", 64'(n), 64'd16);
    check("wd_err", err, 1'b1);
    check("wd_cnt_load", bus.cnt_load, 1'b0);
    check("wd_busy", busy, 1'b0);
    tick();
    stall_done = 1'b0;
    stim_q = '{8'h33};
    run_frame(1'b0);
    check("wd_err_cleared", err, 1'b0);
`else
    n = 0;
    check("err_tied_low", err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/freq_count_sequencer.md
# freq_count_sequencer

Controller that sequences the `frequency_counter` datapath for one Huffman frame. It clears the counter and accepts a byte stream over valid/ready. It feeds each byte into the counter through the counter's level `load` / `done` acknowledge handshake. At end of stream it sweeps the frequency table through the asynchronous `addr` / `freq_out` read port and emits every non-zero `(symbol, frequency)` pair in ascending symbol order for codebook generation.

## Interface
Parameters:
- `TOTAL_W`, 32: width of the total-symbol counter (saturating).
- `TIMEOUT_CYCLES`, 64: counter-handshake watchdog limit. Only used with `FCS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a frame; ignored while `busy`=1.
- `in_data`  in  8  input symbol.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  marks the final symbol of the frame; qualified by `in_valid`.
- `in_ready`  out  1  high only in the ACCEPT state.
- `cnt_clr`  out  1  one-cycle pulse driving the counter's active-high `reset`.
- `cnt_symbol`  out  8  registered symbol driven to the counter.
- `cnt_load`  out  1  registered level load to the counter.
- `cnt_done`  in  1  counter acknowledge.
- `cnt_addr`  out  8  registered table read address.
- `cnt_freq`  in  24  table read data; combinational from `cnt_addr`.
- `out_symbol`  out  8  emitted symbol.
- `out_freq`  out  24  emitted frequency.
- `out_valid`  out  1  output pair valid.
- `out_last`  out  1  high with the pair for the highest symbol seen.
- `out_ready`  in  1  downstream accept.
- `total_count`  out  `TOTAL_W`  symbols counted this frame.
- `distinct_count`  out  9  non-zero pairs emitted this frame (0–256).
- `busy`  out  1  high in every state except IDLE, DONE and ERR.
- `done`  out  1  one-cycle pulse at frame completion.
- `err`  out  1  sticky watchdog error.

## Operation
States: IDLE, CLEAR, ACCEPT, LOAD, RELEASE, SCAN, EMIT, DONE, ERR.

- **Reset (`reset_n`=0 at an edge):** state←IDLE. All outputs 0, including `cnt_addr`, `total_count`, `distinct_count` and `err`. This applies mid-frame as well; `cnt_load` drops immediately.
- **IDLE:** `start` → CLEAR.
- **CLEAR:** drive `cnt_clr`=1 for one cycle, which also clears any stale counter `done`.
  - Zero `total_count`, `distinct_count`, `max_sym` and the `last_seen` flag.
  - Clear `err`.
  - Go to ACCEPT.
- **ACCEPT:** `in_ready`=1. On `in_valid`:
  - Register `cnt_symbol`←`in_data` and `cnt_load`←1.
  - Update `max_sym`←max(`max_sym`, `in_data`).
  - Store `last_seen`←`in_last`.
  - Go to LOAD.
- **LOAD:** hold `cnt_load`=1 until `cnt_done`=1. Then `cnt_load`←0, `total_count`+1 (saturating at all-ones), and go to RELEASE.
- **RELEASE:** wait for `cnt_done`=0. This guarantees the counter sees a fresh rising edge on the next load. Then go to SCAN if `last_seen`, else ACCEPT. On entry to SCAN, `cnt_addr`←0.
- **SCAN:** examine `cnt_freq` each cycle.
  - If non-zero: register `out_symbol`←`cnt_addr`, `out_freq`←`cnt_freq`, `out_valid`←1, `out_last`←(`cnt_addr`==`max_sym`), `distinct_count`+1, and go to EMIT.
  - If zero: `cnt_addr`+1.
  - The scan stops at `max_sym`, which is always non-zero, so `cnt_addr` never wraps.
- **EMIT:** hold the pair stable until `out_ready`. Then `out_valid`←0, and either go to DONE (if `out_last`) or set `cnt_addr`+1 and go to SCAN.
- **DONE:** `done`=1 for one cycle, then IDLE. `total_count` and `distinct_count` hold until the next CLEAR.
- Every input beat carries one symbol, so a frame holds at least one symbol and at least one pair is emitted.
- `in_last` without `in_valid` is ignored.
- `start` while `busy`=1 is ignored.

## Timing
- **Per symbol:** 5 cycles from one input handshake to the next. Handshake edge E0 → load high → counter `done` at E1 → load low at E2 → counter `done` low at E3 → ACCEPT at E4 → next handshake at E5 earliest.
- **Start to first `in_ready`:** 2 cycles (CLEAR, then ACCEPT).
- **Scan:** 1 cycle per zero entry. A non-zero entry gives `out_valid` on the edge after its SCAN cycle.
- **Backpressure:** `out_*` held stable while `out_valid`=1 and `out_ready`=0. `out_valid` does not depend combinationally on `out_ready`.
- **Completion:** `done` pulses the cycle after the `out_last` handshake.

## Configuration
- **`FCS_TIMEOUT_EN` defined:** a cycle counter runs in LOAD and RELEASE and resets on each state change. When it reaches `TIMEOUT_CYCLES`:
  - `cnt_load`←0, `err`←1, state←ERR.
  - ERR has `busy`=0 and accepts `start` (which goes to CLEAR and clears `err`).
- **Undefined:** no watchdog logic; `err` is tied to 0 and the ERR state is unreachable.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with random inputs → all outputs 0, state IDLE; `start` is honoured afterwards.
- Stream 0x00, 0x00, 0x05, 0x03(last) with a behavioural counter → pairs (0x00,2), (0x03,1), (0x05,1,`out_last`); `total_count`=4, `distinct_count`=3; one `done` pulse; 5-cycle spacing between `in_ready` handshakes.
- Single symbol 0xFF(last) → `cnt_addr` sweeps 0..255; one pair (0xFF,1) with `out_last`=1; `distinct_count`=1.
- Hold `out_ready`=0 for 10 cycles during EMIT → `out_valid`, `out_symbol` and `out_freq` unchanged; the scan resumes after acceptance.
- With `FCS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, tie `cnt_done`=0 → `err`=1 after 16 LOAD cycles; `cnt_load`=0; `busy`=0; a new `start` clears `err`.
- Assert `reset_n`=0 mid-frame during LOAD, and pulse `start` while `busy` → `cnt_load` drops at the reset edge; the extra `start` causes no `cnt_clr`.
